payload_deframer: RTL and testbench

PAYLOAD_DEFRAMER -- requirements
Module: payload_deframer

---
 rtl/payload_deframer_pkg.sv | 24 ++
 rtl/payload_deframer_sat_counter.sv | 25 ++
 rtl/payload_deframer.sv | 173 +++++++++++++++++
 tb/tb_payload_deframer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/payload_deframer_pkg.sv
// payload_deframer_pkg
//   Shared definitions for the payload deframer:
//   - DEFAULT_PAYLOAD_BITS / DEFAULT_CNT_W : parameter defaults for the top
//   - state_t                             : deframer FSM state encoding
//   Build option: define PARITY_CHECK_EN to add the trailing parity state.
package payload_deframer_pkg;

  localparam int DEFAULT_PAYLOAD_BITS = 8;
  localparam int DEFAULT_CNT_W        = 8;

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
`endif

endpackage

// File: rtl/payload_deframer_sat_counter.sv
// sat_counter
//   Up-counter that stops at all-ones instead of wrapping.
//   Ports:
//     clk   - clock
//     rst_n - asynchronous active-low reset, clears count
//     inc   - increment request for this cycle
//     count - current value (W bits)
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/payload_deframer.sv
// payload_deframer
//   Collects a PAYLOAD_BITS-long MSB-first payload from a serial stream,
//   starting on the sync_hit pulse that marks payload bit 0. A new sync_hit
//   in the middle of a frame abandons it and restarts on the current bit.
//   Build option: PARITY_CHECK_EN adds a trailing even-parity bit per frame;
//   without it parity_err is constant 0.
//   Ports:
//     clk        - clock
//     rst_n      - asynchronous active-low reset
//     in         - serial bit stream
//     sync_hit   - one-cycle pulse, high while payload bit 0 is on in
//     data_out   - last completed payload, held until the next completion
//     data_valid - one-cycle pulse when data_out updates
//     parity_err - parity failure flag, qualified by data_valid
//     frame_cnt  - saturating count of completed frames
//     abort_cnt  - saturating count of abandoned frames
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for sync_hit; in is ignored
//   ST_SHIFT  | sampling payload bits 1..PAYLOAD_BITS-1
//   ST_PARITY | sampling the parity bit (PARITY_CHECK_EN builds only)
module payload_deframer
  import payload_deframer_pkg::*;
#(
  parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in,
  input  logic                    sync_hit,
  output logic [PAYLOAD_BITS-1:0] data_out,
  output logic                    data_valid,
  output logic                    parity_err,
  output logic [CNT_W-1:0]        frame_cnt,
  output logic [CNT_W-1:0]        abort_cnt
);

  localparam int BCW = $clog2(PAYLOAD_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(PAYLOAD_BITS - 1);

  state_t                  state, state_nxt;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic [PAYLOAD_BITS-1:0] shreg_nxt;
  logic [PAYLOAD_BITS-1:0] payload_done;
  logic [BCW-1:0]          bit_cnt;
  logic                    start_frame;
  logic                    shift_en;
  logic                    complete;
  logic                    abort;

  // Left shift: bit 0 of the frame ends up in the MSB after PAYLOAD_BITS shifts.
  assign shreg_nxt = {shreg[PAYLOAD_BITS-2:0], in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    complete    = 1'b0;
    abort       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sync_hit) begin
          start_frame = 1'b1;
          state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sync_hit) begin
          // Resync wins over completion, even on the last payload bit.
          abort       = 1'b1;
          start_frame = 1'b1;
          state_nxt   = ST_SHIFT;
        end else begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
            state_nxt = ST_PARITY;
`else
            complete  = 1'b1;
            state_nxt = ST_IDLE;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      ST_PARITY: begin
        if (sync_hit) begin
          abort       = 1'b1;
          start_frame = 1'b1;
          state_nxt   = ST_SHIFT;
        end else begin
          complete  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (start_frame) begin
      shreg   <= {{(PAYLOAD_BITS-1){1'b0}}, in};
      bit_cnt <= BCW'(1);
    end else if (shift_en) begin
      shreg <= shreg_nxt;
      if (bit_cnt == LAST_BIT) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  // Payload is already complete in shreg; in carries the parity bit.
  assign payload_done = shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (complete) begin
      parity_err <= ^{shreg, in};
    end
  end
`else
  // The last payload bit is still on in when the frame completes.
  assign payload_done = shreg_nxt;
  assign parity_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= complete;
      if (complete) begin
        data_out <= payload_done;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (complete),
    .count (frame_cnt)
  );

  sat_counter #(.W(CNT_W)) u_abort_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (abort),
    .count (abort_cnt)
  );

endmodule

// File: tb/tb_payload_deframer.sv
// tb_payload_deframer
//   Directed bench for payload_deframer (PAYLOAD_BITS=8). A second instance
//   with CNT_W=2 shares all inputs and shows counter saturation.
module tb_payload_deframer;

  localparam int PB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in;
  logic          sync_hit;
  logic [PB-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic [7:0]    frame_cnt;
  logic [7:0]    abort_cnt;
  logic [PB-1:0] d2_data_out;
  logic          d2_data_valid;
  logic          d2_parity_err;
  logic [1:0]    d2_frame_cnt;
  logic [1:0]    d2_abort_cnt;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int exp_aborts = 0;

  payload_deframer #(.PAYLOAD_BITS(PB), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .sync_hit   (sync_hit),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_cnt  (frame_cnt),
    .abort_cnt  (abort_cnt)
  );

  payload_deframer #(.PAYLOAD_BITS(PB), .CNT_W(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .sync_hit   (sync_hit),
    .data_out   (d2_data_out),
    .data_valid (d2_data_valid),
    .parity_err (d2_parity_err),
    .frame_cnt  (d2_frame_cnt),
    .abort_cnt  (d2_abort_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one bit for one cycle; return 1 time unit after the sampling edge.
  task automatic drive(input logic s, input logic b);
    sync_hit = s;
    in       = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sat2(input int n);
    return (n > 3) ? 32'd3 : 32'(n);
  endfunction

  // Send a full frame starting with sync_hit; parity bit p is used only in
  // parity builds. Returns in the cycle data_valid is expected high.
  task automatic send_frame(input string tag, input logic [7:0] v, input logic p);
    logic exp_perr;
    for (int i = 0; i < PB; i++) begin
      drive(i == 0, v[PB-1-i]);
      if (i < PB - 1) chk({tag, "_no_early_valid"}, 32'(data_valid), 32'd0);
    end
`ifdef PARITY_CHECK_EN
    chk({tag, "_no_valid_before_parity"}, 32'(data_valid), 32'd0);
    drive(1'b0, p);
    exp_perr = ^{v, p};
`else
    exp_perr = 1'b0;
`endif
    exp_frames++;
    chk({tag, "_valid"},      32'(data_valid), 32'd1);
    chk({tag, "_data"},       32'(data_out),   32'(v));
    chk({tag, "_parity_err"}, 32'(parity_err), 32'(exp_perr));
    chk({tag, "_frame_cnt"},  32'(frame_cnt),  32'(exp_frames));
    chk({tag, "_abort_cnt"},  32'(abort_cnt),  32'(exp_aborts));
    chk({tag, "_sat_frame"},  32'(d2_frame_cnt), sat2(exp_frames));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"},      32'(data_out),     32'd0);
    chk({tag, "_valid"},     32'(data_valid),   32'd0);
    chk({tag, "_perr"},      32'(parity_err),   32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt),    32'd0);
    chk({tag, "_abort_cnt"}, 32'(abort_cnt),    32'd0);
    chk({tag, "_sat_frame"}, 32'(d2_frame_cnt), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in       = 1'b0;
    sync_hit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Traffic without sync_hit must be ignored.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, i[0]);
      chk("idle_ignore_valid", 32'(data_valid), 32'd0);
    end
    chk("idle_ignore_frames", 32'(frame_cnt), 32'd0);

    // Basic frame: bits 1,0,1,0,0,1,0,1 -> 0xA5, parity bit 0 (even).
    send_frame("a5_p0", 8'hA5, 1'b0);
    drive(1'b0, 1'b1);
    chk("a5_pulse_ends", 32'(data_valid), 32'd0);
    chk("a5_held",       32'(data_out),   32'hA5);

`ifdef PARITY_CHECK_EN
    // Same payload with odd overall parity must flag an error.
    send_frame("a5_p1", 8'hA5, 1'b1);
    drive(1'b0, 1'b0);
`endif

    // Abort: four bits of a frame, then resync at bit 4 with frame 0x3C.
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    chk("abort_partial_no_valid", 32'(data_valid), 32'd0);
    exp_aborts++;
    send_frame("resync_3c", 8'h3C, 1'b0);
    drive(1'b0, 1'b0);

    // Back-to-back: second sync_hit lands in the data_valid cycle of 0x81.
    send_frame("b2b_81", 8'h81, 1'b0);
    send_frame("b2b_7e", 8'h7E, 1'b0);
    chk("b2b_sat_abort", 32'(d2_abort_cnt), 32'd1);
    drive(1'b0, 1'b0);

    // Reset mid-frame at bit 5 of 0x55.
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("midframe_reset");
    exp_frames = 0;
    exp_aborts = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Rest of the interrupted frame plus idle: nothing may complete.
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, ~i[0]);
      chk("post_reset_no_valid", 32'(data_valid), 32'd0);
    end

    // Fresh frames after reset; the CNT_W=2 instance saturates at 3.
    send_frame("post_rst_c3", 8'hC3, 1'b0);
    send_frame("sat_f2", 8'h01, 1'b1);
    send_frame("sat_f3", 8'hFF, 1'b0);
    send_frame("sat_f4", 8'h00, 1'b0);
    send_frame("sat_f5", 8'h96, 1'b0);
    drive(1'b0, 1'b0);
    chk("final_frame_cnt", 32'(frame_cnt),    32'd5);
    chk("final_sat_frame", 32'(d2_frame_cnt), 32'd3);
    chk("final_abort_cnt", 32'(abort_cnt),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
